// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_pkg
// Brief  : Shared widths, register-index constants and types for writeback.
// Rev    : 1.0  initial release
// ============================================================================
package wb_pkg;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] word_t;
endpackage
`default_nettype wire

// File: rtl/rf15x32.sv
`default_nettype none
// ============================================================================
// Module : rf15x32
// Brief  : R0-R14 storage, one write port, two raw read ports (index 15 reads 0).
// Rev    : 1.0  initial release
// ============================================================================
module rf15x32 #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic [DW-1:0] o_rd1,
    output logic [DW-1:0] o_rd2
);
    localparam int NREG = 15;

    logic [DW-1:0] r_mem [NREG];

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[i] <= '0;
                end else if (i_we && (i_waddr == AW'(i))) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    endgenerate

    // Decoded read; an address with no backing storage falls through to zero.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_ra1 == AW'(i)) o_rd1 = r_mem[i];
            if (i_ra2 == AW'(i)) o_rd2 = r_mem[i];
        end
    end
endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module : wb_stage
// Brief  : Writeback result select, register commit, R15 redirect, retire count.
// Rev    : 1.0  initial release
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int DW = wb_pkg::DW,
    parameter int AW = wb_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pcload_W,
    input  logic          regw_W,
    input  logic          regmem_W,
    input  logic [AW-1:0] regScr_W,
    input  logic [DW-1:0] ALUrslt_W,
    input  logic [DW-1:0] rddata_W,
    input  logic [DW-1:0] pc8_D,
    input  logic [AW-1:0] ra1_D,
    input  logic [AW-1:0] ra2_D,
    output logic [DW-1:0] rd1_D,
    output logic [DW-1:0] rd2_D,
    output logic [DW-1:0] result_W,
    output logic          pc_redirect,
    output logic [DW-1:0] pc_target,
    output logic [31:0]   retired
);
    localparam logic [AW-1:0] c_PC_IDX = AW'(REG_PC);

    logic          w_rf_we;
    logic [DW-1:0] w_raw1;
    logic [DW-1:0] w_raw2;
    logic          r_redirect;
    logic [DW-1:0] r_target;
    logic [31:0]   r_retired;

    assign result_W = regmem_W ? rddata_W : ALUrslt_W;
    assign w_rf_we  = regw_W && (regScr_W != c_PC_IDX);

    rf15x32 #(
        .DW (DW),
        .AW (AW)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_rf_we),
        .i_waddr (regScr_W),
        .i_wdata (result_W),
        .i_ra1   (ra1_D),
        .i_ra2   (ra2_D),
        .o_rd1   (w_raw1),
        .o_rd2   (w_raw2)
    );

    // R15 reads PC+8; otherwise the in-flight write wins over storage.
    always_comb begin
        rd1_D = w_raw1;
        rd2_D = w_raw2;
        if (ra1_D == c_PC_IDX) begin
            rd1_D = pc8_D;
        end else if (regw_W && (regScr_W == ra1_D)) begin
            rd1_D = result_W;
        end
        if (ra2_D == c_PC_IDX) begin
            rd2_D = pc8_D;
        end else if (regw_W && (regScr_W == ra2_D)) begin
            rd2_D = result_W;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect <= 1'b0;
            r_target   <= '0;
            r_retired  <= '0;
        end else begin
            r_redirect <= pcload_W;
            if (pcload_W) begin
                r_target <= result_W;
            end
            if (regw_W || pcload_W) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign pc_redirect = r_redirect;
    assign pc_target   = r_target;
    assign retired     = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_stage
// Brief  : Vector table, directed corner sequences and random model checks.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_stage;
    logic        clk;
    logic        rst;
    logic        pcload_W;
    logic        regw_W;
    logic        regmem_W;
    logic [3:0]  regScr_W;
    logic [31:0] ALUrslt_W;
    logic [31:0] rddata_W;
    logic [31:0] pc8_D;
    logic [3:0]  ra1_D;
    logic [3:0]  ra2_D;
    logic [31:0] rd1_D;
    logic [31:0] rd2_D;
    logic [31:0] result_W;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pcload_W    (pcload_W),
        .regw_W      (regw_W),
        .regmem_W    (regmem_W),
        .regScr_W    (regScr_W),
        .ALUrslt_W   (ALUrslt_W),
        .rddata_W    (rddata_W),
        .pc8_D       (pc8_D),
        .ra1_D       (ra1_D),
        .ra2_D       (ra2_D),
        .rd1_D       (rd1_D),
        .rd2_D       (rd2_D),
        .result_W    (result_W),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pcload;
        logic        regw;
        logic        regmem;
        logic [3:0]  dst;
        logic [31:0] alu;
        logic [31:0] rdd;
        logic [31:0] pc8;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [31:0] e_res;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_redir;
        logic [31:0] e_tgt;
        logic [31:0] e_ret;
    } vec_t;

    vec_t vecs [11];

    // Reference state for the random phase
    logic [31:0] m_regs [15];
    logic        m_redir;
    logic [31:0] m_tgt;
    logic [31:0] m_ret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pl, input logic rw, input logic rm, input logic [3:0] d,
                         input logic [31:0] a, input logic [31:0] r, input logic [31:0] p,
                         input logic [3:0] a1, input logic [3:0] a2);
        pcload_W  = pl;
        regw_W    = rw;
        regmem_W  = rm;
        regScr_W  = d;
        ALUrslt_W = a;
        rddata_W  = r;
        pc8_D     = p;
        ra1_D     = a1;
        ra2_D     = a2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] ra, input logic [31:0] res);
        if (ra == 4'd15) return pc8_D;
        if (regw_W && regScr_W == ra) return res;
        return m_regs[ra];
    endfunction

    initial begin
        rst = 1'b1;
        idle();

        // pcload, regw, regmem, dst, alu, rdd, pc8, ra1, ra2, res, rd1, rd2, redir, tgt, ret
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd3,  32'h0000FFFF, 32'h0,        32'h0,   4'd3,  4'd4,
                     32'h0000FFFF, 32'h0000FFFF, 32'h0,        1'b1, 32'h0000FFFF, 32'd1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd4,  32'h0000FFFF, 32'h0,        32'h0,   4'd3,  4'd4,
                     32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h0000FFFF, 32'd2};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'd7,  32'h00000100, 32'hDEADBEEF, 32'h0,   4'd7,  4'd3,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'h0000FFFF, 1'b0, 32'h0000FFFF, 32'd3};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h208, 4'd7,  4'd15,
                     32'h0,        32'hDEADBEEF, 32'h208,      1'b0, 32'h0000FFFF, 32'd3};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd15, 32'h00000055, 32'h0,        32'h208, 4'd15, 4'd15,
                     32'h55,       32'h208,      32'h208,      1'b0, 32'h0000FFFF, 32'd4};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd5,  32'h00000011, 32'h0,        32'h208, 4'd5,  4'd6,
                     32'h11,       32'h11,       32'h0,        1'b0, 32'h0000FFFF, 32'd5};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd5,  32'h00000022, 32'h0,        32'h208, 4'd5,  4'd5,
                     32'h22,       32'h22,       32'h22,       1'b0, 32'h0000FFFF, 32'd6};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'd5,  32'h00000033, 32'h0,        32'h208, 4'd5,  4'd5,
                     32'h33,       32'h22,       32'h22,       1'b0, 32'h0000FFFF, 32'd6};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd9,  32'h00001234, 32'h0,        32'h208, 4'd0,  4'd1,
                     32'h1234,     32'h0,        32'h0,        1'b1, 32'h00001234, 32'd7};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'd15, 32'h0,        32'h00005678, 32'h10,  4'd15, 4'd9,
                     32'h5678,     32'h10,       32'h0,        1'b1, 32'h00005678, 32'd8};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        32'h0,   4'd15, 4'd7,
                     32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 32'h00005678, 32'd8};

        do_reset();
        #1;
        check("reset_redirect", {31'd0, pc_redirect}, 32'd0);
        check("reset_target", pc_target, 32'd0);
        check("reset_retired", retired, 32'd0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 11; i++) begin
            to_negedge();
            drive(vecs[i].pcload, vecs[i].regw, vecs[i].regmem, vecs[i].dst, vecs[i].alu,
                  vecs[i].rdd, vecs[i].pc8, vecs[i].ra1, vecs[i].ra2);
            #1;
            check($sformatf("vec%0d_result", i), result_W, vecs[i].e_res);
            check($sformatf("vec%0d_rd1", i), rd1_D, vecs[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), rd2_D, vecs[i].e_rd2);
            edge_then_settle();
            check($sformatf("vec%0d_redirect", i), {31'd0, pc_redirect}, {31'd0, vecs[i].e_redir});
            check($sformatf("vec%0d_target", i), pc_target, vecs[i].e_tgt);
            check($sformatf("vec%0d_retired", i), retired, vecs[i].e_ret);
        end

        // ---------------- asynchronous reset mid-redirect ----------------
        to_negedge();
        drive(1'b1, 1'b1, 1'b0, 4'd2, 32'hCAFE0001, 32'h0, 32'h0, 4'd2, 4'd2);
        @(posedge clk);
        #2;
        check("pre_reset_redirect", {31'd0, pc_redirect}, 32'd1);
        idle();
        rst = 1'b1;
        #1;
        check("async_reset_redirect", {31'd0, pc_redirect}, 32'd0);
        check("async_reset_target", pc_target, 32'd0);
        check("async_reset_retired", retired, 32'd0);
        for (int r = 0; r < 15; r++) begin
            ra1_D = 4'(r);
            ra2_D = 4'(14 - r);
            #1;
            check($sformatf("async_reset_r%0d", r), rd1_D, 32'd0);
            check($sformatf("async_reset_p2_r%0d", 14 - r), rd2_D, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // ---------------- randomized run against model ----------------
        for (int r = 0; r < 15; r++) m_regs[r] = 32'd0;
        m_redir = 1'b0;
        m_tgt   = 32'd0;
        m_ret   = 32'd0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] exp_res;
            to_negedge();
            drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            #1;
            exp_res = regmem_W ? rddata_W : ALUrslt_W;
            check("rnd_result", result_W, exp_res);
            check("rnd_rd1", rd1_D, model_read(ra1_D, exp_res));
            check("rnd_rd2", rd2_D, model_read(ra2_D, exp_res));
            if (regw_W && regScr_W != 4'd15) m_regs[regScr_W] = exp_res;
            m_redir = pcload_W;
            if (pcload_W) m_tgt = exp_res;
            if (regw_W || pcload_W) m_ret = m_ret + 32'd1;
            edge_then_settle();
            check("rnd_redirect", {31'd0, pc_redirect}, {31'd0, m_redir});
            check("rnd_target", pc_target, m_tgt);
            check("rnd_retired", retired, m_ret);
        end

        // ---------------- back-to-back redirects ----------------
        to_negedge();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 32'hA0A0A0A0, 32'h0, 32'h0, 4'd0, 4'd0);
        edge_then_settle();
        check("b2b_first_redirect", {31'd0, pc_redirect}, 32'd1);
        check("b2b_first_target", pc_target, 32'hA0A0A0A0);
        to_negedge();
        drive(1'b1, 1'b0, 1'b1, 4'd0, 32'h0, 32'hB1B1B1B1, 32'h0, 4'd0, 4'd0);
        edge_then_settle();
        check("b2b_second_redirect", {31'd0, pc_redirect}, 32'd1);
        check("b2b_second_target", pc_target, 32'hB1B1B1B1);
        to_negedge();
        idle();
        edge_then_settle();
        check("b2b_drop_redirect", {31'd0, pc_redirect}, 32'd0);
        check("b2b_hold_target", pc_target, 32'hB1B1B1B1);

        // ---------------- retire counter wrap ----------------
        to_negedge();
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        drive(1'b0, 1'b1, 1'b0, 4'd1, 32'h1, 32'h0, 32'h0, 4'd1, 4'd1);
        edge_then_settle();
        check("retired_wrap", retired, 32'd0);
        to_negedge();
        idle();
        edge_then_settle();
        check("retired_hold_after_wrap", retired, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
